// File: rtl/clk_ratio_monitor_if.sv
// clk_ratio_monitor_if: divided-clock stimulus and measurement results bundled between driver and monitor
interface clk_ratio_monitor_if #(parameter int DivRatio_Width = 3);
  logic                      i_div_clk;
  logic                      i_meas_en;
  logic [DivRatio_Width-1:0] i_exp_ratio;
  logic [DivRatio_Width:0]   o_high_cnt;
  logic [DivRatio_Width:0]   o_low_cnt;
  logic [DivRatio_Width:0]   o_ratio;
  logic                      o_valid;
  logic                      o_locked;
  logic [1:0]                o_err_code;
  modport master (output i_div_clk, i_meas_en, i_exp_ratio,
                  input  o_high_cnt, o_low_cnt, o_ratio, o_valid, o_locked, o_err_code);
  modport slave  (input  i_div_clk, i_meas_en, i_exp_ratio,
                  output o_high_cnt, o_low_cnt, o_ratio, o_valid, o_locked, o_err_code);
endinterface

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures high/low time of a divided clock in reference cycles and tracks lock to an expected ratio
module clk_ratio_monitor #(
  parameter int DivRatio_Width = 3,
  parameter int Lock_Count     = 4
) (
  input  logic                  i_ref_clk,
  input  logic                  i_rst_n,
  clk_ratio_monitor_if.slave    bus
);
  localparam int CW = DivRatio_Width + 1;
  localparam int LW = $clog2(Lock_Count + 1);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_e;
  state_e          state_q;
  logic            div_q;
  logic [CW-1:0]   cnt_q, high_q;
  logic [LW-1:0]   lock_q;
  logic            rise, fall, timeout;
  logic [CW-1:0]   ratio_d, diff_d;
  logic [1:0]      chk_d;
  logic [LW-1:0]   lock_d;
  assign rise    = bus.i_div_clk & ~div_q;
  assign fall    = ~bus.i_div_clk & div_q;
  assign timeout = (state_q != IDLE) && (cnt_q == '1);
  assign ratio_d = high_q + cnt_q;
  assign diff_d  = (high_q > cnt_q) ? high_q - cnt_q : cnt_q - high_q;
  // Legal duty: equal halves for even ratios, halves differing by one for odd
  assign chk_d   = (ratio_d != CW'(bus.i_exp_ratio)) ? 2'b01 :
                   (ratio_d[0] ? (diff_d != CW'(1)) : (diff_d != '0)) ? 2'b10 : 2'b00;
  assign lock_d  = (lock_q == LW'(Lock_Count)) ? lock_q : lock_q + 1'b1;
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      div_q          <= 1'b0;
      cnt_q          <= '0;
      high_q         <= '0;
      lock_q         <= '0;
      bus.o_high_cnt <= '0;
      bus.o_low_cnt  <= '0;
      bus.o_ratio    <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_locked   <= 1'b0;
      bus.o_err_code <= 2'b00;
    end else begin
      div_q          <= bus.i_div_clk;
      bus.o_valid    <= 1'b0;
      bus.o_err_code <= 2'b00;
      if (!bus.i_meas_en) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        lock_q       <= '0;
        bus.o_locked <= 1'b0;
      end else if (timeout) begin
        state_q        <= WAIT_RISE;
        cnt_q          <= '0;
        lock_q         <= '0;
        bus.o_locked   <= 1'b0;
        bus.o_err_code <= 2'b11;
      end else begin
        case (state_q)
          IDLE: state_q <= WAIT_RISE;
          WAIT_RISE: begin
            cnt_q   <= rise ? CW'(1) : cnt_q + 1'b1;
            state_q <= rise ? MEAS_HIGH : WAIT_RISE;
          end
          MEAS_HIGH: begin
            if (fall) begin
              high_q  <= cnt_q;
              cnt_q   <= CW'(1);
              state_q <= MEAS_LOW;
            end else if (bus.i_div_clk) cnt_q <= cnt_q + 1'b1;
          end
          default: begin
            if (rise) begin
              bus.o_high_cnt <= high_q;
              bus.o_low_cnt  <= cnt_q;
              bus.o_ratio    <= ratio_d;
              bus.o_valid    <= 1'b1;
              bus.o_err_code <= chk_d;
              lock_q         <= (chk_d == 2'b00) ? lock_d : '0;
              bus.o_locked   <= (chk_d == 2'b00) && (lock_d == LW'(Lock_Count));
              cnt_q          <= CW'(1);
              state_q        <= MEAS_HIGH;
            end else if (!bus.i_div_clk) cnt_q <= cnt_q + 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: directed checks of period measurement, duty/ratio errors, lock, timeout, disable and reset
module tb_clk_ratio_monitor;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   nv = 0;
  int   nto = 0;
  clk_ratio_monitor_if #(.DivRatio_Width(3)) bus ();
  clk_ratio_monitor #(.DivRatio_Width(3), .Lock_Count(4)) dut (
    .i_ref_clk(clk),
    .i_rst_n  (rst_n),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask
  // One reference cycle with the given divided-clock level; outputs settle 1ns after the edge
  task automatic step(input logic d);
    bus.i_div_clk = d;
    @(posedge clk);
    #1;
    if (bus.o_valid) nv++;
    if (bus.o_err_code == 2'b11) nto++;
  endtask
  // Finish a period whose rising sample was already stepped, then step the next rise
  task automatic prh(input int h, input int l);
    repeat (h - 1) step(1'b1);
    repeat (l) step(1'b0);
    step(1'b1);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.i_meas_en = 1'b0;
    bus.i_exp_ratio = 3'd4;
    bus.i_div_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_high", bus.o_high_cnt, 0);
    chk("rst_low", bus.o_low_cnt, 0);
    chk("rst_ratio", bus.o_ratio, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_locked", bus.o_locked, 0);
    chk("rst_err", bus.o_err_code, 0);
    rst_n = 1'b1;
    bus.i_meas_en = 1'b1;
    step(1'b0);
    step(1'b0);
    nv = 0;
    repeat (4) begin
      step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    end
    chk("r4_nv3", nv, 3);
    chk("r4_lock3", bus.o_locked, 0);
    step(1'b1);
    chk("r4_valid", bus.o_valid, 1);
    chk("r4_high", bus.o_high_cnt, 2);
    chk("r4_low", bus.o_low_cnt, 2);
    chk("r4_ratio", bus.o_ratio, 4);
    chk("r4_err", bus.o_err_code, 0);
    chk("r4_lock4", bus.o_locked, 1);
    step(1'b1);
    chk("r4_pulse", bus.o_valid, 0);
    chk("r4_hold", bus.o_ratio, 4);
    step(1'b0); step(1'b0); step(1'b1);
    chk("duty_pre_lock", bus.o_locked, 1);
    prh(3, 1);
    chk("duty_valid", bus.o_valid, 1);
    chk("duty_err", bus.o_err_code, 2);
    chk("duty_lock", bus.o_locked, 0);
    chk("duty_high", bus.o_high_cnt, 3);
    chk("duty_low", bus.o_low_cnt, 1);
    repeat (3) prh(2, 2);
    chk("relock3", bus.o_locked, 0);
    prh(2, 2);
    chk("relock4", bus.o_locked, 1);
    bus.i_exp_ratio = 3'd5;
    prh(2, 3);
    chk("r5_ratio", bus.o_ratio, 5);
    chk("r5_low", bus.o_low_cnt, 3);
    chk("r5_err", bus.o_err_code, 0);
    chk("r5_lock", bus.o_locked, 1);
    bus.i_exp_ratio = 3'd6;
    prh(2, 3);
    chk("r6_err_a", bus.o_err_code, 1);
    chk("r6_lock", bus.o_locked, 0);
    prh(2, 3);
    chk("r6_err_b", bus.o_err_code, 1);
    chk("r6_valid", bus.o_valid, 1);
    bus.i_exp_ratio = 3'd4;
    repeat (4) prh(2, 2);
    chk("to_prelock", bus.o_locked, 1);
    nto = 0;
    repeat (14) step(1'b1);
    chk("to_cnt15", bus.o_err_code, 0);
    step(1'b1);
    chk("to_err", bus.o_err_code, 3);
    chk("to_lock", bus.o_locked, 0);
    chk("to_valid", bus.o_valid, 0);
    step(1'b1);
    step(1'b0);
    chk("to_once", nto, 1);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    nv = 0;
    step(1'b1);
    chk("after_to_pub", nv, 1);
    step(1'b1);
    step(1'b0);
    bus.i_meas_en = 1'b0;
    nv = 0;
    step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0);
    chk("dis_nv", nv, 0);
    chk("dis_high", bus.o_high_cnt, 2);
    chk("dis_low", bus.o_low_cnt, 2);
    chk("dis_ratio", bus.o_ratio, 4);
    bus.i_meas_en = 1'b1;
    step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    chk("reen_nv0", nv, 0);
    step(1'b1);
    chk("reen_nv1", nv, 1);
    chk("reen_ratio", bus.o_ratio, 4);
    step(1'b1);
    step(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_high", bus.o_high_cnt, 0);
    chk("arst_low", bus.o_low_cnt, 0);
    chk("arst_ratio", bus.o_ratio, 0);
    #2;
    rst_n = 1'b1;
    nv = 0;
    step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    chk("arst_nv0", nv, 0);
    step(1'b1);
    chk("arst_nv1", nv, 1);
    chk("arst_ratio4", bus.o_ratio, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
